// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state encoding, opcode constants and select codes for mc_control_unit
// MC_UTYPE_EN adds the UI state for LUI/AUIPC.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
`ifdef MC_UTYPE_EN
        S_UI       = 4'd11,
`endif
        S_FAULT    = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCA_ZERO   = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic [2:0] imm_decode(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_ITYPE: imm_decode = IMM_I;
            OP_STORE:          imm_decode = IMM_S;
            OP_BRANCH:         imm_decode = IMM_B;
            OP_JAL:            imm_decode = IMM_J;
            OP_LUI, OP_AUIPC:  imm_decode = IMM_U;
            default:           imm_decode = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_branch_cond.sv
// rtl/mc_branch_cond.sv - branch taken / illegal evaluation from funct3 and ALU flags
module mc_branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle RV32 control FSM with memory-wait timeout and sticky fault
// MC_UTYPE_EN enables decoding of LUI/AUIPC through the UI state.
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] state,
    output logic       retire,
    output logic       fault
);

    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t        state_q;
    state_t        cur;
    state_t        nxt;
    logic [TW-1:0] wait_cnt;
    logic          waiting;
    logic          expired;
    logic          taken;
    logic          illegal;

    // Reset overrides the registered state so the outputs look like FETCH during the reset cycle itself.
    assign cur     = rst ? S_FETCH : state_q;
    assign waiting = mem_req & ~mem_ready;
    assign expired = (TIMEOUT > 0) && waiting && (wait_cnt == LAST_WAIT);

    mc_branch_cond u_branch_cond (
        .funct3  (funct3),
        .zero    (zero),
        .lt      (lt),
        .ltu     (ltu),
        .taken   (taken),
        .illegal (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q <= nxt;
            if (nxt != state_q) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH: begin
                if (mem_ready)    nxt = S_DECODE;
                else if (expired) nxt = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXECR;
                    OP_ITYPE:          nxt = S_EXECI;
                    OP_BRANCH:         nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
`ifdef MC_UTYPE_EN
                    OP_LUI, OP_AUIPC:  nxt = S_UI;
`endif
                    default:           nxt = S_FAULT;
                endcase
            end
            S_MEMADR:  nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)    nxt = S_MEMWB;
                else if (expired) nxt = S_FAULT;
            end
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)    nxt = S_FETCH;
                else if (expired) nxt = S_FAULT;
            end
            S_EXECR, S_EXECI: nxt = S_ALUWB;
            S_ALUWB:          nxt = S_FETCH;
            S_BRANCH:         nxt = illegal ? S_FAULT : S_FETCH;
            S_JAL:            nxt = S_ALUWB;
`ifdef MC_UTYPE_EN
            S_UI:             nxt = S_ALUWB;
`endif
            default:          nxt = S_FAULT;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        retire     = 1'b0;
        fault      = (cur == S_FAULT);
        imm_src    = imm_decode(opcode);
        state      = cur;
        case (cur)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready & ~rst;
                pc_write   = mem_ready & ~rst;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                retire    = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_SUB;
                pc_write  = taken & ~illegal;
                retire    = ~illegal;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
`ifdef MC_UTYPE_EN
            S_UI: begin
                alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized instruction-level check of mc_control_unit against a trace model
module tb_mc_control_unit;
    import mc_pkg::*;

    localparam int T = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq;
        logic       mwr;
        logic       irw;
        logic       pcw;
        logic       rgw;
        logic       adr;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [1:0] rs;
        logic [2:0] imm;
        logic       ret;
        logic       flt;
    } obs_t;

    typedef struct {
        obs_t       exp;
        logic       rdy;
        logic       r;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       z;
        logic       l;
        logic       lu;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_write, ir_write, pc_write, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic [3:0] state;
    logic       retire, fault;

    int checks = 0;
    int errors = 0;
    ent_t tr[$];
    logic [6:0] i_op;
    logic [2:0] i_f3;
    logic       i_z, i_l, i_lu;

    always #5 clk = ~clk;

    mc_control_unit #(.TIMEOUT(T), .TW(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .adr_src(adr_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .state(state),
        .retire(retire), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] imm_ref(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0010011: return 3'b000;
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    // Outputs each state asserts unconditionally; cycle-dependent bits are patched by the trace builder.
    function automatic obs_t base(input state_t s);
        obs_t o = '0;
        o.st  = s;
        o.imm = imm_ref(i_op);
        case (s)
            S_FETCH:    begin o.mreq = 1; o.b = 2'b10; o.rs = 2'b10; end
            S_DECODE:   begin o.a = 2'b01; o.b = 2'b01; end
            S_MEMADR:   begin o.a = 2'b10; o.b = 2'b01; end
            S_MEMREAD:  begin o.mreq = 1; o.adr = 1; end
            S_MEMWB:    begin o.rs = 2'b01; o.rgw = 1; o.ret = 1; end
            S_MEMWRITE: begin o.mreq = 1; o.mwr = 1; o.adr = 1; end
            S_EXECR:    begin o.a = 2'b10; o.op = 2'b10; end
            S_EXECI:    begin o.a = 2'b10; o.b = 2'b01; o.op = 2'b10; end
            S_ALUWB:    begin o.rgw = 1; o.ret = 1; end
            S_BRANCH:   begin o.a = 2'b10; o.op = 2'b01; end
            S_JAL:      begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1; end
            S_FAULT:    o.flt = 1;
            default:    ;
        endcase
        return o;
    endfunction

    task automatic push(input obs_t o, input logic rdy, input logic r);
        ent_t e;
        e.exp = o; e.rdy = rdy; e.r = r;
        e.opc = i_op; e.f3 = i_f3; e.z = i_z; e.l = i_l; e.lu = i_lu;
        tr.push_back(e);
    endtask

    task automatic push_any(input obs_t o);
        push(o, 1'($urandom_range(1)), 1'b0);
    endtask

    task automatic push_rst();
        push(base(S_FETCH), 1'($urandom_range(1)), 1'b1);
    endtask

    task automatic fault_tail(output logic died);
        for (int i = 0; i < 3; i++) push_any(base(S_FAULT));
        died = 1'b1;
    endtask

    // A memory phase: w not-ready cycles, then either completion or a timeout into FAULT.
    task automatic mem_phase(input state_t s, input int w, input obs_t done, output logic died);
        died = 1'b0;
        for (int i = 0; i < w && i < T; i++) push(base(s), 1'b0, 1'b0);
        if (w >= T) fault_tail(died);
        else push(done, 1'b1, 1'b0);
    endtask

    task automatic build(input int wf, input int wm);
        obs_t o;
        logic died;
        logic tk, bad;
        o = base(S_FETCH); o.irw = 1; o.pcw = 1;
        mem_phase(S_FETCH, wf, o, died);
        if (!died) begin
            push_any(base(S_DECODE));
            case (i_op)
                7'b0000011: begin
                    push_any(base(S_MEMADR));
                    mem_phase(S_MEMREAD, wm, base(S_MEMREAD), died);
                    if (!died) push_any(base(S_MEMWB));
                end
                7'b0100011: begin
                    push_any(base(S_MEMADR));
                    o = base(S_MEMWRITE); o.ret = 1;
                    mem_phase(S_MEMWRITE, wm, o, died);
                end
                7'b0110011: begin push_any(base(S_EXECR)); push_any(base(S_ALUWB)); end
                7'b0010011: begin push_any(base(S_EXECI)); push_any(base(S_ALUWB)); end
                7'b1101111: begin push_any(base(S_JAL)); push_any(base(S_ALUWB)); end
                7'b1100011: begin
                    bad = (i_f3 == 3'b010) || (i_f3 == 3'b011);
                    case (i_f3)
                        3'b000:  tk = i_z;
                        3'b001:  tk = !i_z;
                        3'b100:  tk = i_l;
                        3'b101:  tk = !i_l;
                        3'b110:  tk = i_lu;
                        3'b111:  tk = !i_lu;
                        default: tk = 1'b0;
                    endcase
                    o = base(S_BRANCH); o.pcw = tk; o.ret = !bad;
                    push_any(o);
                    if (bad) fault_tail(died);
                end
`ifdef MC_UTYPE_EN
                7'b0110111, 7'b0010111: begin
                    o = base(S_UI); o.b = 2'b01;
                    o.a = (i_op == 7'b0110111) ? 2'b11 : 2'b01;
                    push_any(o);
                    push_any(base(S_ALUWB));
                end
`endif
                default: fault_tail(died);
            endcase
        end
        if (died) push_rst();
    endtask

    task automatic play();
        ent_t e;
        obs_t g;
        while (tr.size() > 0) begin
            e = tr.pop_front();
            @(posedge clk);
            #1;
            rst = e.r; mem_ready = e.rdy;
            opcode = e.opc; funct3 = e.f3; zero = e.z; lt = e.l; ltu = e.lu;
            @(negedge clk);
            g = {state, mem_req, mem_write, ir_write, pc_write, reg_write, adr_src,
                 alu_src_a, alu_src_b, alu_op, result_src, imm_src, retire, fault};
            check(e.r ? "reset" : "cycle", 32'(g), 32'(e.exp));
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic z, input logic l,
                             input logic lu, input int wf, input int wm, input logic may_cut);
        int k;
        i_op = o; i_f3 = f; i_z = z; i_l = l; i_lu = lu;
        build(wf, wm);
        if (may_cut && $urandom_range(7) == 0 && tr.size() > 1) begin
            k = $urandom_range(tr.size() - 1, 1);
            while (tr.size() > k) void'(tr.pop_back());
            push_rst();
        end
        play();
    endtask

    function automatic int rand_wait();
        return ($urandom_range(9) == 0) ? int'($urandom_range(5, 4)) : int'($urandom_range(3));
    endfunction

    logic [6:0] ops [11] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                             7'b1101111, 7'b0110111, 7'b0010111, 7'b1100111, 7'b1100011, 7'b0110011};

    initial begin
        logic [6:0] ro;
        i_op = 7'd0; i_f3 = 3'd0; i_z = 0; i_l = 0; i_lu = 0;
        push_rst(); push_rst();
        play();

        run_instr(7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0);
        run_instr(7'b0000011, 3'b010, 0, 0, 0, 2, 3, 0);
        run_instr(7'b1100011, 3'b000, 0, 1, 1, 0, 0, 0);
        run_instr(7'b1100011, 3'b110, 1, 0, 1, 1, 0, 0);
        run_instr(7'b1100011, 3'b010, 1, 1, 1, 0, 0, 0);
        run_instr(7'b0110011, 3'b000, 0, 0, 0, 4, 0, 0);
        run_instr(7'b0100011, 3'b010, 0, 0, 0, 1, 2, 0);
        run_instr(7'b0000011, 3'b010, 0, 0, 0, 0, 5, 0);
        run_instr(7'b0110111, 3'b000, 0, 0, 0, 0, 0, 0);
        run_instr(7'b0010111, 3'b000, 0, 0, 0, 0, 0, 0);
        run_instr(7'b1101111, 3'b000, 0, 0, 0, 0, 0, 0);
        run_instr(7'b1100111, 3'b000, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            ro = ($urandom_range(7) == 0) ? 7'($urandom) : ops[$urandom_range(10)];
            run_instr(ro, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      rand_wait(), rand_wait(), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
